// File: rtl/reorder_buffer.sv
// Reorder buffer: 2-wide dispatch, NUM_FU completion ports, in-order retire of up to 2 per cycle.
// Retire is decided from registered state; free/commit are registered (visible the cycle after the retire edge); dispatch stalls when count > DEPTH-2.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int NUM_FU = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    disp_valid1,
  input  logic                    disp_has_rd1,
  input  logic [4:0]              disp_arch_rd1,
  input  logic [5:0]              disp_p_rd1,
  input  logic [5:0]              disp_p_old_rd1,
  input  logic                    disp_valid2,
  input  logic                    disp_has_rd2,
  input  logic [4:0]              disp_arch_rd2,
  input  logic [5:0]              disp_p_rd2,
  input  logic [5:0]              disp_p_old_rd2,
  output logic                    disp_ready,
  output logic [IDX_W-1:0]        disp_idx1,
  output logic [IDX_W-1:0]        disp_idx2,
  input  logic [NUM_FU-1:0]       cmpl_valid,
  input  logic [NUM_FU*IDX_W-1:0] cmpl_idx,
  output logic                    free_valid1,
  output logic                    free_valid2,
  output logic [5:0]              free_reg1,
  output logic [5:0]              free_reg2,
  output logic                    commit_valid1,
  output logic                    commit_valid2,
  output logic [4:0]              commit_arch_rd1,
  output logic [4:0]              commit_arch_rd2,
  output logic [5:0]              commit_p_rd1,
  output logic [5:0]              commit_p_rd2,
  output logic [IDX_W:0]          rob_count,
  output logic                    rob_empty
);

  typedef struct packed {
    logic       valid;
    logic       done;
    logic       has_rd;
    logic [4:0] arch_rd;
    logic [5:0] p_rd;
    logic [5:0] p_old_rd;
  } rob_entry_t;

  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W:0]   READY_MAX = (IDX_W+1)'(DEPTH - 2);

  rob_entry_t       ent_q [DEPTH];
  rob_entry_t       ent_d [DEPTH];
  rob_entry_t       e0, e1;
  logic [IDX_W-1:0] head_q, tail_q, head_nx;
  logic [IDX_W:0]   count_q, count_d;
  logic             acc1, acc2, ret1, ret2, fr1, fr2;

  assign disp_ready = (count_q <= READY_MAX);
  assign disp_idx1  = tail_q;
  assign disp_idx2  = tail_q + IDX_ONE;
  assign acc1       = disp_ready & disp_valid1;
  assign acc2       = acc1 & disp_valid2;

  assign head_nx = head_q + IDX_ONE;
  assign e0      = ent_q[head_q];
  assign e1      = ent_q[head_nx];
  assign ret1    = e0.valid & e0.done;
  assign ret2    = ret1 & e1.valid & e1.done;
  // Register 0 is architecturally pinned and must never return to the pool.
  assign fr1     = ret1 & e0.has_rd & (e0.p_old_rd != 6'd0);
  assign fr2     = ret2 & e1.has_rd & (e1.p_old_rd != 6'd0);

  assign count_d = count_q + (IDX_W+1)'(acc1) + (IDX_W+1)'(acc2)
                           - (IDX_W+1)'(ret1) - (IDX_W+1)'(ret2);
  assign rob_count = count_q;

  // Order matters: completion, then retire clear, then dispatch write (dispatch wins on a shared index).
  always_comb begin
    ent_d = ent_q;
    for (int k = 0; k < NUM_FU; k++) begin
      if (cmpl_valid[k] && ent_q[cmpl_idx[k*IDX_W +: IDX_W]].valid)
        ent_d[cmpl_idx[k*IDX_W +: IDX_W]].done = 1'b1;
    end
    if (ret1) begin
      ent_d[head_q].valid = 1'b0;
      ent_d[head_q].done  = 1'b0;
    end
    if (ret2) begin
      ent_d[head_nx].valid = 1'b0;
      ent_d[head_nx].done  = 1'b0;
    end
    if (acc1)
      ent_d[tail_q] = '{valid: 1'b1, done: 1'b0, has_rd: disp_has_rd1, arch_rd: disp_arch_rd1,
                        p_rd: disp_p_rd1, p_old_rd: disp_p_old_rd1};
    if (acc2)
      ent_d[disp_idx2] = '{valid: 1'b1, done: 1'b0, has_rd: disp_has_rd2, arch_rd: disp_arch_rd2,
                           p_rd: disp_p_rd2, p_old_rd: disp_p_old_rd2};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rob_empty <= 1'b1;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q    <= head_q + IDX_W'(ret1) + IDX_W'(ret2);
      tail_q    <= tail_q + IDX_W'(acc1) + IDX_W'(acc2);
      count_q   <= count_d;
      rob_empty <= (count_d == '0);
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid1   <= 1'b0;
      commit_valid2   <= 1'b0;
      commit_arch_rd1 <= '0;
      commit_arch_rd2 <= '0;
      commit_p_rd1    <= '0;
      commit_p_rd2    <= '0;
      free_valid1     <= 1'b0;
      free_valid2     <= 1'b0;
      free_reg1       <= '0;
      free_reg2       <= '0;
    end else begin
      commit_valid1   <= ret1;
      commit_valid2   <= ret2;
      commit_arch_rd1 <= ret1 ? e0.arch_rd : 5'd0;
      commit_arch_rd2 <= ret2 ? e1.arch_rd : 5'd0;
      commit_p_rd1    <= ret1 ? e0.p_rd : 6'd0;
      commit_p_rd2    <= ret2 ? e1.p_rd : 6'd0;
      free_valid1     <= fr1;
      free_valid2     <= fr2;
      free_reg1       <= fr1 ? e0.p_old_rd : 6'd0;
      free_reg2       <= fr2 ? e1.p_old_rd : 6'd0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: vector table plus directed multi-cycle sequences;
// a negedge monitor pops expected commits/frees from scoreboard queues.
`timescale 1ns/1ps
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_valid1, disp_has_rd1, disp_valid2, disp_has_rd2;
  logic [4:0]  disp_arch_rd1, disp_arch_rd2;
  logic [5:0]  disp_p_rd1, disp_p_old_rd1, disp_p_rd2, disp_p_old_rd2;
  logic        disp_ready;
  logic [3:0]  disp_idx1, disp_idx2;
  logic [2:0]  cmpl_valid;
  logic [11:0] cmpl_idx;
  logic        free_valid1, free_valid2, commit_valid1, commit_valid2, rob_empty;
  logic [5:0]  free_reg1, free_reg2, commit_p_rd1, commit_p_rd2;
  logic [4:0]  commit_arch_rd1, commit_arch_rd2;
  logic [4:0]  rob_count;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(16), .IDX_W(4), .NUM_FU(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid1(disp_valid1), .disp_has_rd1(disp_has_rd1), .disp_arch_rd1(disp_arch_rd1),
    .disp_p_rd1(disp_p_rd1), .disp_p_old_rd1(disp_p_old_rd1),
    .disp_valid2(disp_valid2), .disp_has_rd2(disp_has_rd2), .disp_arch_rd2(disp_arch_rd2),
    .disp_p_rd2(disp_p_rd2), .disp_p_old_rd2(disp_p_old_rd2),
    .disp_ready(disp_ready), .disp_idx1(disp_idx1), .disp_idx2(disp_idx2),
    .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
    .free_valid1(free_valid1), .free_valid2(free_valid2), .free_reg1(free_reg1), .free_reg2(free_reg2),
    .commit_valid1(commit_valid1), .commit_valid2(commit_valid2),
    .commit_arch_rd1(commit_arch_rd1), .commit_arch_rd2(commit_arch_rd2),
    .commit_p_rd1(commit_p_rd1), .commit_p_rd2(commit_p_rd2),
    .rob_count(rob_count), .rob_empty(rob_empty)
  );

  typedef struct { logic [4:0] rd; logic [5:0] p; } cm_t;
  typedef struct { logic v1, v2, h1, h2; logic [5:0] o1, o2; int acc; int frees; } vec_t;

  cm_t        exp_cm[$];
  logic [5:0] exp_fr[$];
  logic [3:0] pending[$];
  logic [3:0] fresh[$];
  int         total = 0, bad = 0;
  int         commits_seen = 0, frees_seen = 0, disp_cnt = 0;
  logic [3:0] tb_tail = 4'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic pop_cm(input string nm, input logic [4:0] rd, input logic [5:0] p);
    cm_t e;
    commits_seen++;
    if (exp_cm.size() == 0) begin
      total++; bad++;
      $display("FAIL %s unexpected retire actual rd=%0d p_rd=%0d required=none", nm, rd, p);
    end else begin
      e = exp_cm.pop_front();
      check({nm, "_arch_rd"}, rd, e.rd);
      check({nm, "_p_rd"}, p, e.p);
    end
  endtask

  task automatic pop_fr(input string nm, input logic [5:0] r);
    frees_seen++;
    if (exp_fr.size() == 0) begin
      total++; bad++;
      $display("FAIL %s unexpected free actual=%0d required=none", nm, r);
    end else check(nm, r, exp_fr.pop_front());
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (commit_valid1) pop_cm("commit1", commit_arch_rd1, commit_p_rd1);
      if (commit_valid2) pop_cm("commit2", commit_arch_rd2, commit_p_rd2);
      if (free_valid1) pop_fr("free1", free_reg1);
      if (free_valid2) pop_fr("free2", free_reg2);
      if (!commit_valid1) check("idle1_data", {commit_arch_rd1, commit_p_rd1, free_valid1, free_reg1}, 0);
      if (!commit_valid2) check("idle2_data", {commit_arch_rd2, commit_p_rd2, free_valid2, free_reg2}, 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    disp_valid1 = 1'b0; disp_valid2 = 1'b0; cmpl_valid = 3'b000;
    foreach (fresh[i]) pending.push_back(fresh[i]);
    fresh.delete();
  endtask

  task automatic set_cmpl(input logic [2:0] v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    cmpl_valid = v;
    cmpl_idx   = {c, b, a};
  endtask

  // Acceptance model: ready when occupancy (dispatched minus observed commits) <= 14.
  task automatic drive_disp(input logic v1, input logic v2, input logic h1, input logic h2,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [5:0] p1,
                            input logic [5:0] p2, input logic [5:0] o1, input logic [5:0] o2,
                            output int acc);
    logic       rdy;
    logic [3:0] t2;
    rdy = (disp_cnt - commits_seen) <= 14;
    t2  = tb_tail + 4'd1;
    check("disp_idx1", disp_idx1, tb_tail);
    check("disp_idx2", disp_idx2, t2);
    disp_valid1 = v1; disp_has_rd1 = h1; disp_arch_rd1 = r1; disp_p_rd1 = p1; disp_p_old_rd1 = o1;
    disp_valid2 = v2; disp_has_rd2 = h2; disp_arch_rd2 = r2; disp_p_rd2 = p2; disp_p_old_rd2 = o2;
    acc = 0;
    if (rdy && v1) begin
      exp_cm.push_back('{r1, p1});
      if (h1 && o1 != 6'd0) exp_fr.push_back(o1);
      fresh.push_back(tb_tail);
      tb_tail = tb_tail + 4'd1;
      acc = 1;
      if (v2) begin
        exp_cm.push_back('{r2, p2});
        if (h2 && o2 != 6'd0) exp_fr.push_back(o2);
        fresh.push_back(tb_tail);
        tb_tail = tb_tail + 4'd1;
        acc = 2;
      end
    end
    disp_cnt += acc;
  endtask

  task automatic pick_cmpl(input bit all);
    logic [2:0] v;
    logic [3:0] ix [3];
    int         j;
    v = 3'b000;
    for (int k = 0; k < 3; k++) begin
      ix[k] = 4'd0;
      if (pending.size() > 0 && (all || $urandom_range(0, 1) == 1)) begin
        j = $urandom_range(0, pending.size() - 1);
        ix[k] = pending[j];
        pending.delete(j);
        v[k] = 1'b1;
      end
    end
    set_cmpl(v, ix[0], ix[1], ix[2]);
  endtask

  task automatic complete_pending();
    while (pending.size() > 0) begin
      pick_cmpl(1'b1);
      tick();
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (!(rob_empty && exp_cm.size() == 0 && exp_fr.size() == 0) && n < 100) begin
      tick();
      n++;
    end
    tick(); tick();
    check({nm, "_empty"}, rob_empty, 1);
    check({nm, "_count"}, rob_count, 0);
    check({nm, "_leftover"}, exp_cm.size() + exp_fr.size(), 0);
    exp_cm.delete(); exp_fr.delete();
  endtask

  initial begin
    vec_t       vt[7];
    int         acc, base, basef, issued, cyc;
    logic [3:0] i0, h0;
    logic       v2, hh1, hh2;
    logic [5:0] oo1, oo2;

    vt[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'd5,  6'd6,  2, 2};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 6'd7,  6'd8,  1, 1};
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd9,  6'd10, 0, 0};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'd11, 6'd0,  2, 0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd0,  6'd12, 2, 0};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd13, 6'd14, 0, 0};
    vt[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd15, 6'd0,  2, 1};

    rst_n = 1'b1;
    disp_valid1 = 1'b0; disp_has_rd1 = 1'b0; disp_arch_rd1 = 5'd0; disp_p_rd1 = 6'd0; disp_p_old_rd1 = 6'd0;
    disp_valid2 = 1'b0; disp_has_rd2 = 1'b0; disp_arch_rd2 = 5'd0; disp_p_rd2 = 6'd0; disp_p_old_rd2 = 6'd0;
    cmpl_valid = 3'b000; cmpl_idx = 12'd0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", rob_count, 0);
    check("rst_empty", rob_empty, 1);
    rst_n = 1'b1;
    tick();

    // Reset with 5 live entries discards them silently.
    drive_disp(1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 6'd40, 6'd41, 6'd1, 6'd2, acc); tick();
    drive_disp(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 6'd42, 6'd43, 6'd3, 6'd4, acc); tick();
    drive_disp(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 5'd6, 6'd44, 6'd45, 6'd5, 6'd6, acc); tick();
    check("live_count", rob_count, 5);
    check("live_idx1", disp_idx1, 5);
    rst_n = 1'b0;
    exp_cm.delete(); exp_fr.delete(); pending.delete();
    tb_tail = 4'd0; disp_cnt = 0; commits_seen = 0; frees_seen = 0;
    tick();
    check("mid_rst_count", rob_count, 0);
    check("mid_rst_empty", rob_empty, 1);
    check("mid_rst_valids", {commit_valid1, commit_valid2, free_valid1, free_valid2}, 0);
    check("mid_rst_idx1", disp_idx1, 0);
    rst_n = 1'b1;
    tick();

    // Dual dispatch, out-of-order completion, paired retire.
    i0 = tb_tail;
    drive_disp(1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 5'd6, 6'd33, 6'd34, 6'd5, 6'd6, acc); tick();
    pending.delete();
    set_cmpl(3'b001, i0 + 4'd1, 4'd0, 4'd0); tick();
    set_cmpl(3'b001, i0, 4'd0, 4'd0); tick();
    check("dual_e2_cv1", commit_valid1, 0);
    tick();
    check("dual_cv", {commit_valid1, commit_valid2}, 2'b11);
    check("dual_free_reg1", free_reg1, 5);
    check("dual_free_reg2", free_reg2, 6);
    check("dual_p_rd1", commit_p_rd1, 33);
    check("dual_p_rd2", commit_p_rd2, 34);
    drain("dual");

    // Head incomplete blocks younger completed entries.
    i0 = tb_tail;
    drive_disp(1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 5'd8,  6'd35, 6'd36, 6'd7, 6'd8,  acc); tick();
    drive_disp(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 5'd10, 6'd37, 6'd38, 6'd9, 6'd10, acc); tick();
    pending.delete();
    set_cmpl(3'b111, i0 + 4'd1, i0 + 4'd2, i0 + 4'd3); tick();
    repeat (3) tick();
    check("blocked_cv1", commit_valid1, 0);
    check("blocked_count", rob_count, 4);
    set_cmpl(3'b001, i0, 4'd0, 4'd0); tick();
    tick();
    check("unblock1_cv", {commit_valid1, commit_valid2}, 2'b11);
    check("unblock1_p", {commit_p_rd1, commit_p_rd2}, {6'd35, 6'd36});
    tick();
    check("unblock2_cv", {commit_valid1, commit_valid2}, 2'b11);
    check("unblock2_p", {commit_p_rd1, commit_p_rd2}, {6'd37, 6'd38});
    drain("blocked");

    foreach (vt[i]) begin
      base = commits_seen; basef = frees_seen;
      drive_disp(vt[i].v1, vt[i].v2, vt[i].h1, vt[i].h2, 5'(i + 1), 5'(i + 17),
                 6'(40 + i), 6'(50 + i), vt[i].o1, vt[i].o2, acc);
      tick();
      check($sformatf("vec%0d_count", i), rob_count, vt[i].acc);
      complete_pending();
      drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d_commits", i), commits_seen - base, vt[i].acc);
      check($sformatf("vec%0d_frees", i), frees_seen - basef, vt[i].frees);
    end

    // Completion to an invalid index, then dispatch colliding with completion.
    i0 = tb_tail;
    set_cmpl(3'b001, i0, 4'd0, 4'd0); tick();
    set_cmpl(3'b011, i0, i0 + 4'd1, 4'd0);
    drive_disp(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 6'd60, 6'd61, 6'd3, 6'd4, acc); tick();
    pending.delete();
    repeat (3) tick();
    check("collide_count", rob_count, 2);
    check("collide_cv1", commit_valid1, 0);
    set_cmpl(3'b111, i0, i0, i0 + 4'd1); tick();
    drain("collide");

    // Fill to 15, dispatch ignored, one retire restores ready.
    for (int i = 0; i < 7; i++) begin
      drive_disp(1'b1, 1'b1, 1'b1, 1'b1, 5'(i + 1), 5'(i + 9), 6'(20 + 2 * i), 6'(21 + 2 * i),
                 6'(i + 1), 6'(i + 9), acc);
      tick();
    end
    drive_disp(1'b1, 1'b0, 1'b1, 1'b1, 5'd30, 5'd31, 6'd62, 6'd63, 6'd30, 6'd31, acc); tick();
    check("full_count", rob_count, 15);
    check("full_ready", disp_ready, 0);
    drive_disp(1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 6'd3, 6'd4, 6'd5, 6'd6, acc); tick();
    check("ignored_count", rob_count, 15);
    h0 = pending.pop_front();
    set_cmpl(3'b001, h0, 4'd0, 4'd0); tick();
    check("still_full_ready", disp_ready, 0);
    tick();
    check("drop_count", rob_count, 14);
    check("ready_back", disp_ready, 1);
    complete_pending();
    drain("full");

    // 40 instructions with random completion order across 3 FUs.
    issued = 0; cyc = 0; base = commits_seen;
    while (issued < 40 && cyc < 1000) begin
      if ((disp_cnt - commits_seen) <= 14) begin
        v2  = (issued < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
        hh1 = ($urandom_range(0, 3) != 0);
        hh2 = ($urandom_range(0, 3) != 0);
        oo1 = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        oo2 = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        drive_disp(1'b1, v2, hh1, hh2, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   6'($urandom_range(1, 63)), 6'($urandom_range(1, 63)), oo1, oo2, acc);
        issued += acc;
      end
      pick_cmpl(1'b0);
      tick();
      cyc++;
    end
    complete_pending();
    drain("wrap");
    check("wrap_issued", issued, 40);
    check("wrap_commits", commits_seen - base, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
